// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: per-stage stall vector, timed multi-cycle stall and flush/redirect control.
// Optional STALL_WATCHDOG_EN adds a sticky watchdog on prolonged PC stalls.
module pipe_stall_ctrl #(
  parameter int NUM_STAGES = 6,
  parameter int CNT_W = 6,
  parameter int PC_W = 32,
  parameter int TIMEOUT = 63,
  localparam int SW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  timed_req,
  input  logic [SW-1:0]         timed_stage,
  input  logic [CNT_W-1:0]      timed_cycles,
  input  logic                  flush_req,
  input  logic [PC_W-1:0]       flush_pc,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [PC_W-1:0]       new_pc,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam logic [SW:0] NS = NUM_STAGES[SW:0];
  localparam logic [NUM_STAGES-1:0] ONE = NUM_STAGES'(1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stage_q;
  logic flush_q;
  logic [PC_W-1:0] pc_q;
  logic accept;
  logic [NUM_STAGES-1:0] r, th;
  assign accept = timed_req && cnt_q == '0 && timed_cycles != '0 && !flush_q && {1'b0, timed_stage} < NS;
  assign r = stall_req | ((cnt_q != '0) ? ONE << stage_q : '0) | (accept ? ONE << timed_stage : '0);
  // every register at or below the highest requester holds
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_th
    assign th[i] = |(r >> i);
  end
  assign stall = (rst || flush_q) ? '0 : th;
  assign cnt_d = flush_q ? '0 : accept ? timed_cycles - CNT_W'(1) : (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
  assign flush = flush_q;
  assign new_pc = pc_q;
  assign busy = cnt_q != '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      stage_q <= '0;
      flush_q <= 1'b0;
      pc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      stage_q <= accept ? timed_stage : stage_q;
      flush_q <= flush_req;
      pc_q <= flush_req ? flush_pc : pc_q;
    end
  end
`ifdef STALL_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO = WW'(TIMEOUT);
  logic [WW-1:0] wd_q, wd_d;
  logic err_q;
  assign wd_d = (!stall[0] || flush_q) ? '0 : (wd_q == TO) ? wd_q : wd_q + WW'(1);
  assign timeout_err = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      err_q <= err_q | (wd_d == TO);
    end
  end
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed table, corner sequences and random run against a behavioural model.
module tb_pipe_stall_ctrl;
  localparam int N = 6;
  localparam int T = 8;
  logic clk = 0, rst = 1;
  logic [N-1:0] stall_req = '0;
  logic timed_req = 0;
  logic [2:0] timed_stage = '0;
  logic [5:0] timed_cycles = '0;
  logic flush_req = 0;
  logic [31:0] flush_pc = '0;
  logic [N-1:0] stall;
  logic flush, busy, timeout_err;
  logic [31:0] new_pc;
  int checks = 0, errors = 0;

  pipe_stall_ctrl #(.NUM_STAGES(N), .CNT_W(6), .PC_W(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .timed_req(timed_req),
    .timed_stage(timed_stage), .timed_cycles(timed_cycles), .flush_req(flush_req),
    .flush_pc(flush_pc), .stall(stall), .flush(flush), .new_pc(new_pc),
    .busy(busy), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int rem, mstage, wd;
  bit mflush, merr, acc;
  logic [31:0] mpc;
  logic [N-1:0] es;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    rem = 0; mstage = 0; wd = 0; mflush = 0; merr = 0; mpc = '0;
  endtask

  task automatic apply(input logic [N-1:0] sr, input logic tr, input logic [2:0] ts,
                       input logic [5:0] tc, input logic fr, input logic [31:0] fp);
    logic [N-1:0] rq;
    int h;
    @(negedge clk);
    stall_req = sr; timed_req = tr; timed_stage = ts; timed_cycles = tc;
    flush_req = fr; flush_pc = fp;
    #1;
    acc = tr && rem == 0 && tc != 0 && !mflush && int'(ts) < N;
    rq = sr;
    if (rem != 0) rq[mstage] = 1'b1;
    if (acc) rq[ts] = 1'b1;
    h = -1;
    for (int i = 0; i < N; i++) if (rq[i]) h = i;
    es = '0;
    for (int i = 0; i <= h; i++) es[i] = 1'b1;
    if (mflush) es = '0;
    chk("stall", 32'(stall), 32'(es));
    chk("busy", 32'(busy), 32'(rem != 0));
    chk("flush", 32'(flush), 32'(mflush));
    chk("new_pc", new_pc, mpc);
    chk("timeout_err", 32'(timeout_err), 32'(merr));
  endtask

  task automatic adv();
    @(posedge clk);
    if (mflush) rem = 0;
    else if (acc) rem = int'(timed_cycles) - 1;
    else if (rem > 0) rem--;
    if (acc) mstage = int'(timed_stage);
    wd = es[0] ? ((wd < T) ? wd + 1 : T) : 0;
`ifdef STALL_WATCHDOG_EN
    if (wd == T) merr = 1;
`endif
    mflush = flush_req;
    if (flush_req) mpc = flush_pc;
  endtask

  typedef struct {
    logic [N-1:0] sr; logic tr; logic [2:0] ts; logic [5:0] tc; logic fr; logic [31:0] pc;
    logic [N-1:0] es; logic eb; logic ef; logic [31:0] epc;
  } vec_t;
  vec_t tv[23];

  initial begin
    tv[0]  = '{6'b001000, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 0};
    tv[1]  = '{6'b000100, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0};
    tv[2]  = '{6'b001100, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 0};
    tv[3]  = '{6'b100000, 0, 0, 0, 0, 0, 6'b111111, 0, 0, 0};
    tv[4]  = '{6'b000000, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0};
    tv[5]  = '{6'b000000, 1, 3, 4, 0, 0, 6'b001111, 0, 0, 0};
    tv[6]  = '{6'b000000, 0, 0, 0, 0, 0, 6'b001111, 1, 0, 0};
    tv[7]  = '{6'b000000, 1, 5, 7, 0, 0, 6'b001111, 1, 0, 0};
    tv[8]  = '{6'b000000, 0, 0, 0, 0, 0, 6'b001111, 1, 0, 0};
    tv[9]  = '{6'b000000, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0};
    tv[10] = '{6'b000000, 1, 4, 0, 0, 0, 6'b000000, 0, 0, 0};
    tv[11] = '{6'b000000, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0};
    tv[12] = '{6'b000000, 1, 6, 3, 0, 0, 6'b000000, 0, 0, 0};
    tv[13] = '{6'b000000, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0};
    tv[14] = '{6'b000000, 1, 1, 10, 0, 0, 6'b000011, 0, 0, 0};
    tv[15] = '{6'b000000, 0, 0, 0, 0, 0, 6'b000011, 1, 0, 0};
    tv[16] = '{6'b000000, 0, 0, 0, 0, 0, 6'b000011, 1, 0, 0};
    tv[17] = '{6'b000000, 0, 0, 0, 1, 32'h100, 6'b000011, 1, 0, 0};
    tv[18] = '{6'b001000, 0, 0, 0, 0, 0, 6'b000000, 1, 1, 32'h100};
    tv[19] = '{6'b000000, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h100};
    tv[20] = '{6'b000000, 1, 2, 5, 1, 32'h200, 6'b000111, 0, 0, 32'h100};
    tv[21] = '{6'b000000, 1, 3, 2, 0, 0, 6'b000000, 1, 1, 32'h200};
    tv[22] = '{6'b000000, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h200};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_new_pc", new_pc, 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    @(negedge clk) rst = 0;
    for (int k = 0; k < 23; k++) begin
      apply(tv[k].sr, tv[k].tr, tv[k].ts, tv[k].tc, tv[k].fr, tv[k].pc);
      chk($sformatf("tv%0d_stall", k), 32'(stall), 32'(tv[k].es));
      chk($sformatf("tv%0d_busy", k), 32'(busy), 32'(tv[k].eb));
      chk($sformatf("tv%0d_flush", k), 32'(flush), 32'(tv[k].ef));
      chk($sformatf("tv%0d_new_pc", k), new_pc, tv[k].epc);
      adv();
    end
    // reset in the middle of a timed stall
    apply('0, 1, 3, 8, 0, 0); adv();
    apply('0, 0, 0, 0, 0, 0); adv();
    apply('0, 0, 0, 0, 0, 0); adv();
    chk("pre_rst_busy", 32'(busy), 1);
    @(negedge clk);
    stall_req = 6'b001000; rst = 1;
    #1;
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 0;
    for (int k = 0; k < 3; k++) begin
      apply('0, 0, 0, 0, 0, 0);
      chk("post_rst_stall", 32'(stall), 0);
      adv();
    end
    // watchdog: stall_req[2] held TIMEOUT cycles
    for (int k = 0; k < T; k++) begin
      apply(6'b000100, 0, 0, 0, 0, 0);
      chk("wd_early", 32'(timeout_err), 0);
      adv();
    end
    for (int k = 0; k < 2; k++) begin
      apply('0, 0, 0, 0, 0, 0);
`ifdef STALL_WATCHDOG_EN
      chk("wd_sticky", 32'(timeout_err), 1);
`else
      chk("wd_absent", 32'(timeout_err), 0);
`endif
      adv();
    end
    for (int k = 0; k < 400; k++) begin
      apply(($urandom_range(3) == 0) ? N'($urandom) : '0, $urandom_range(3) == 0,
            3'($urandom_range(7)), 6'($urandom_range(12)), $urandom_range(7) == 0, $urandom);
      adv();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
